// File: rtl/cic_supervisor.sv
// cic_supervisor: sequencer for the lockout-chip emulator core.
// Owns the core's reset and seed, holds the host console in reset while the core restarts,
// switches region on a long button press and retries in the other region on lockout failure.
//
// Optional feature macro: CIC_AUTO_RETRY_EN (defined: automatic retry with region toggle;
// undefined: a dead core goes straight to FAIL and the retry counter is removed).
//
// Ports:
//   clk        core clock (same as the emulator core)
//   rst        synchronous active-high reset
//   btn_n      front-panel reset button, active low, asynchronous
//   cic_dead   dead flag from the emulator core
//   cic_rst    reset to the emulator core
//   cic_seed   seed to the emulator core (equals region)
//   region     current region, 0 = NTSC/60 Hz, 1 = PAL/50 Hz
//   host_hold  holds the console in reset
//   fail       retries exhausted
//   led_pal    region indicator, region & ~fail
//   led_ntsc   region indicator, ~region & ~fail
module cic_supervisor #(
  parameter int unsigned RST_HOLD       = 1024,
  parameter int unsigned DEBOUNCE       = 64,
  parameter int unsigned LONG_PRESS     = 4000000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter bit          REGION_DEFAULT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  input  logic cic_dead,
  output logic cic_rst,
  output logic cic_seed,
  output logic region,
  output logic host_hold,
  output logic fail,
  output logic led_pal,
  output logic led_ntsc
);

  localparam int unsigned HW  = $clog2(RST_HOLD + 1);
  localparam int unsigned DBW = $clog2(DEBOUNCE + 1);

  if (RST_HOLD < 2 || MAX_RETRY > 3) begin : g_param_check
    $error("cic_supervisor: RST_HOLD must be >= 2 and MAX_RETRY must fit in 2 bits");
  end

  typedef enum logic [2:0] {
    StRestart,
    StRun,
    StPress,
    StRelease,
    StRetry,
    StFail
  } state_t;

  // Button synchronizer and debouncer
  logic [1:0]     sync_q;
  logic           btn_db_q;
  logic [DBW-1:0] db_cnt_q;
  logic           db_flip;
  logic           db_rise;

  // btn_db changes on the edge where db_flip is high; db_rise lets the FSM act on that same edge.
  assign db_flip = (sync_q[1] != btn_db_q) && (db_cnt_q == DBW'(DEBOUNCE - 1));
  assign db_rise = db_flip & sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= 2'b00;
      btn_db_q <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[0], ~btn_n};
      if (sync_q[1] == btn_db_q) begin
        db_cnt_q <= '0;
      end else if (db_flip) begin
        btn_db_q <= sync_q[1];
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DBW'(1);
      end
    end
  end

  // Sequencer
  state_t        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [23:0]   press_cnt_q, press_cnt_d;
  logic          region_q, region_d;
  logic          cic_rst_q, cic_rst_d;
  logic          host_hold_q, host_hold_d;
  logic          fail_q, fail_d;
  logic          led_pal_q, led_ntsc_q;
`ifdef CIC_AUTO_RETRY_EN
  logic [1:0]    retry_cnt_q, retry_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = '0;
    press_cnt_d = press_cnt_q;
    region_d    = region_q;
`ifdef CIC_AUTO_RETRY_EN
    retry_cnt_d = retry_cnt_q;
`endif
    unique case (state_q)
      StRestart: begin
        if (hold_cnt_q == HW'(RST_HOLD - 1)) begin
          state_d = StRun;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      StRun: begin
        // A dead core takes priority over a simultaneous button edge.
        if (cic_dead) begin
          state_d = StRetry;
        end else if (db_rise) begin
          state_d     = StPress;
          press_cnt_d = '0;
        end
      end
      StPress: begin
        if (!btn_db_q) begin
          state_d = StRestart;
`ifdef CIC_AUTO_RETRY_EN
          retry_cnt_d = '0;
`endif
        end else if (press_cnt_q == 24'(LONG_PRESS - 1)) begin
          state_d  = StRelease;
          region_d = ~region_q;
`ifdef CIC_AUTO_RETRY_EN
          retry_cnt_d = '0;
`endif
        end else begin
          press_cnt_d = press_cnt_q + 24'd1;
        end
      end
      StRelease: begin
        if (!btn_db_q) begin
          state_d = StRestart;
        end
      end
      StRetry: begin
`ifdef CIC_AUTO_RETRY_EN
        if (retry_cnt_q < 2'(MAX_RETRY)) begin
          state_d     = StRestart;
          retry_cnt_d = retry_cnt_q + 2'd1;
          region_d    = ~region_q;
        end else begin
          state_d = StFail;
        end
`else
        state_d = StFail;
`endif
      end
      StFail: begin
        if (db_rise) begin
          state_d = StRelease;
`ifdef CIC_AUTO_RETRY_EN
          retry_cnt_d = '0;
`endif
        end
      end
      default: state_d = StRestart;
    endcase

    // Outputs are decoded from the next state so they come straight out of flops.
    cic_rst_d   = (state_d == StRestart) || (state_d == StRelease) || (state_d == StFail);
    host_hold_d = cic_rst_d;
    fail_d      = (state_d == StFail);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRestart;
      hold_cnt_q  <= '0;
      press_cnt_q <= '0;
      region_q    <= REGION_DEFAULT;
      cic_rst_q   <= 1'b1;
      host_hold_q <= 1'b1;
      fail_q      <= 1'b0;
      led_pal_q   <= REGION_DEFAULT;
      led_ntsc_q  <= ~REGION_DEFAULT;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      press_cnt_q <= press_cnt_d;
      region_q    <= region_d;
      cic_rst_q   <= cic_rst_d;
      host_hold_q <= host_hold_d;
      fail_q      <= fail_d;
      led_pal_q   <= region_d & ~fail_d;
      led_ntsc_q  <= ~region_d & ~fail_d;
    end
  end

`ifdef CIC_AUTO_RETRY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retry_cnt_q <= '0;
    end else begin
      retry_cnt_q <= retry_cnt_d;
    end
  end
`endif

  assign cic_rst   = cic_rst_q;
  assign host_hold = host_hold_q;
  assign region    = region_q;
  assign cic_seed  = region_q;
  assign fail      = fail_q;
  assign led_pal   = led_pal_q;
  assign led_ntsc  = led_ntsc_q;

endmodule
